regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by NREQ requesters competing for one RegFile write port.
// Each requester i holds req_valid[i], req_dR and req_wData steady until it sees
// req_valid[i] && req_ready[i] at a rising clock edge. That edge is the transfer.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_dR;
    logic [32*NREQ-1:0] req_wData;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_dR,
        output req_wData,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dR,
        input  req_wData,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that gives writeback requesters access to the single RegFile write port.
// It also holds the 32-entry busy scoreboard that the issue stage uses to find pending writes.
module regfile_wb_arbiter #(
    parameter int NREQ         = 3,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  req,
    input  logic                 mark_en,
    input  logic [4:0]           mark_reg,
    input  logic [4:0]           rA,
    input  logic [4:0]           rB,
    output logic                 aBusy,
    output logic                 bBusy,
    output logic                 wEnable,
    output logic [4:0]           dR,
    output logic [31:0]          wData,
    output logic                 idle
);
    localparam int PW = (NREQ > 2) ? 2 : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   cand;
    logic            xfer;
    logic [NREQ-1:0] grant;
    logic [4:0]      dr_arr [NREQ];
    logic [31:0]     wd_arr [NREQ];
    logic [31:0]     busy;
    logic [31:0]     busy_next;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            dr_arr[i] = req.req_dR[5*i +: 5];
            wd_arr[i] = req.req_wData[32*i +: 32];
        end
    end

    // Search starts one past the last winner, so the last winner has the lowest priority.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        cand  = ptr;
        xfer  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!xfer && !reset && req.req_valid[cand]) begin
                xfer = 1'b1;
                gidx = cand;
            end
        end
        if (xfer) grant[gidx] = 1'b1;
    end

    assign req.req_ready = grant;

    // A clear and a set in the same cycle leave the bit set, because the set is applied last.
    always_comb begin
        busy_next = busy;
        if (wEnable) busy_next[dR] = 1'b0;
        if (mark_en) busy_next[mark_reg] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= PW'(NREQ - 1);
            busy    <= '0;
            wEnable <= 1'b0;
            dR      <= '0;
            wData   <= '0;
        end else begin
            busy    <= busy_next;
            wEnable <= 1'b0;
            if (xfer) begin
                ptr     <= gidx;
                dR      <= dr_arr[gidx];
                wData   <= wd_arr[gidx];
                wEnable <= !(ZERO_PROTECT && (dr_arr[gidx] == 5'd0));
            end
        end
    end

    assign aBusy = busy[rA];
    assign bBusy = busy[rB];
    assign idle  = (busy == '0) && !wEnable && (req.req_valid == '0);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: grant vectors from a table, hand-written multi-cycle sequences,
// and random traffic compared each cycle against a scoreboard-level reference model.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        mark_en;
    logic [4:0]  mark_reg, rA, rB;
    logic        aBusy, bBusy, wEnable, idle;
    logic [4:0]  dR;
    logic [31:0] wData;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .ZERO_PROTECT(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (bus.slave),
        .mark_en  (mark_en),
        .mark_reg (mark_reg),
        .rA       (rA),
        .rB       (rB),
        .aBusy    (aBusy),
        .bBusy    (bBusy),
        .wEnable  (wEnable),
        .dR       (dR),
        .wData    (wData),
        .idle     (idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] d, input logic [31:0] w);
        bus.req_valid[i]          = v;
        bus.req_dR[5*i +: 5]      = d;
        bus.req_wData[32*i +: 32] = w;
    endtask

    task automatic drop(input int i);
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_dR    = '0;
        bus.req_wData = '0;
        mark_en  = 1'b0;
        mark_reg = '0;
        rA = '0;
        rB = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  d0, d1, d2;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [4:0]  exp_dr;
        logic [31:0] exp_wd;
    } vec_t;

    localparam logic [31:0] W0 = 32'hA0A0_0001;
    localparam logic [31:0] W1 = 32'hB1B1_0002;
    localparam logic [31:0] W2 = 32'hDEAD_BEEF;

    vec_t vecs[8];

    // reference model state
    bit [31:0]   busy_m;
    int          ptr_m;
    logic [36:0] exp_q[$];

    initial begin
        int gi;
        int j;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [36:0] head;
        logic [4:0]  d;

        reset = 1'b1;
        clear_inputs();

        vecs[0] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 32'h0};
        vecs[1] = '{3'b001, 5'd3, 5'd4, 5'd9, 3'b001, 1'b1, 5'd3, W0};
        vecs[2] = '{3'b010, 5'd3, 5'd4, 5'd9, 3'b010, 1'b1, 5'd4, W1};
        vecs[3] = '{3'b100, 5'd3, 5'd4, 5'd9, 3'b100, 1'b1, 5'd9, W2};
        vecs[4] = '{3'b110, 5'd3, 5'd4, 5'd9, 3'b010, 1'b1, 5'd4, W1};
        vecs[5] = '{3'b101, 5'd3, 5'd4, 5'd9, 3'b001, 1'b1, 5'd3, W0};
        vecs[6] = '{3'b111, 5'd3, 5'd4, 5'd9, 3'b001, 1'b1, 5'd3, W0};
        vecs[7] = '{3'b010, 5'd3, 5'd0, 5'd9, 3'b010, 1'b0, 5'd0, 32'h0};

        do_reset();
        #1;
        chk("reset_ready", 32'(bus.req_ready), 32'h0);
        chk("reset_wen", 32'(wEnable), 32'h0);
        chk("reset_dr", 32'(dR), 32'h0);
        chk("reset_wdata", wData, 32'h0);
        chk("reset_idle", 32'(idle), 32'h1);

        // Grant table: each vector starts from reset, when requester 0 has the highest priority.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            set_req(0, vecs[v].valid[0], vecs[v].d0, W0);
            set_req(1, vecs[v].valid[1], vecs[v].d1, W1);
            set_req(2, vecs[v].valid[2], vecs[v].d2, W2);
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(bus.req_ready), 32'(vecs[v].exp_ready));
            chk($sformatf("vec%0d_idle", v), 32'(idle), 32'(vecs[v].valid == 3'b000));
            @(negedge clk);
            clear_inputs();
            #1;
            chk($sformatf("vec%0d_wen", v), 32'(wEnable), 32'(vecs[v].exp_wen));
            if (vecs[v].exp_wen) begin
                chk($sformatf("vec%0d_dr", v), 32'(dR), 32'(vecs[v].exp_dr));
                chk($sformatf("vec%0d_wdata", v), wData, vecs[v].exp_wd);
            end
            chk($sformatf("vec%0d_bbusy_r0", v), 32'(bBusy), 32'h0);
        end

        // All three requesters held valid: grants rotate 0,1,2 and the writes come out back to back.
        do_reset();
        set_req(0, 1'b1, 5'd5, W0);
        set_req(1, 1'b1, 5'd6, W1);
        set_req(2, 1'b1, 5'd7, W2);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("rr_ready%0d", c), 32'(bus.req_ready), 32'(3'b001 << c));
            if (c > 0) begin
                chk($sformatf("rr_wen%0d", c), 32'(wEnable), 32'h1);
                chk($sformatf("rr_dr%0d", c), 32'(dR), 32'(5 + c - 1));
            end
            @(negedge clk);
            drop(c);
        end
        #1;
        chk("rr_wen3", 32'(wEnable), 32'h1);
        chk("rr_dr3", 32'(dR), 32'd7);
        chk("rr_ready_none", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        #1;
        chk("hold_wen", 32'(wEnable), 32'h0);
        chk("hold_dr", 32'(dR), 32'd7);
        chk("hold_wdata", wData, W2);
        chk("hold_idle", 32'(idle), 32'h1);

        // Marking r12 makes it busy until its writeback; the busy output does not see a same-cycle mark.
        do_reset();
        mark_en = 1'b1; mark_reg = 5'd12; rA = 5'd12;
        #1;
        chk("mark_no_fwd", 32'(aBusy), 32'h0);
        @(negedge clk);
        mark_en = 1'b0;
        #1;
        chk("mark_busy1", 32'(aBusy), 32'h1);
        chk("mark_not_idle", 32'(idle), 32'h0);
        @(negedge clk);
        set_req(0, 1'b1, 5'd12, W0);
        #1;
        chk("mark_busy2", 32'(aBusy), 32'h1);
        chk("mark_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        drop(0);
        #1;
        chk("mark_wen", 32'(wEnable), 32'h1);
        chk("mark_wen_dr", 32'(dR), 32'd12);
        chk("mark_busy_wcycle", 32'(aBusy), 32'h1);
        @(negedge clk);
        #1;
        chk("mark_cleared", 32'(aBusy), 32'h0);
        chk("mark_idle", 32'(idle), 32'h1);

        // A new mark of r12 in the same cycle as its write must leave r12 busy.
        mark_en = 1'b1; mark_reg = 5'd12;
        set_req(0, 1'b1, 5'd12, W0);
        #1;
        chk("setwin_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        drop(0);
        #1;
        chk("setwin_wen", 32'(wEnable), 32'h1);
        @(negedge clk);
        mark_en = 1'b0;
        #1;
        chk("setwin_busy", 32'(aBusy), 32'h1);
        @(negedge clk);
        #1;
        chk("setwin_busy_hold", 32'(aBusy), 32'h1);

        // A write to r0 completes the handshake but produces no write, and r0 can never be busy.
        rB = 5'd0;
        mark_en = 1'b1; mark_reg = 5'd0;
        set_req(1, 1'b1, 5'd0, 32'h0000_1234);
        #1;
        chk("zero_ready", 32'(bus.req_ready), 32'h2);
        @(negedge clk);
        drop(1);
        mark_en = 1'b0;
        #1;
        chk("zero_wen", 32'(wEnable), 32'h0);
        chk("zero_bbusy", 32'(bBusy), 32'h0);
        @(negedge clk);
        #1;
        chk("zero_wen2", 32'(wEnable), 32'h0);

        // Reset during a pending write: the write is dropped, busy bits clear, and priority returns to requester 0.
        do_reset();
        set_req(0, 1'b1, 5'd3, W0);
        mark_en = 1'b1; mark_reg = 5'd20; rA = 5'd20;
        @(negedge clk);
        drop(0);
        mark_en = 1'b0;
        set_req(1, 1'b1, 5'd8, W1);
        reset = 1'b1;
        #1;
        chk("rst_ready_forced", 32'(bus.req_ready), 32'h0);
        chk("rst_busy_before", 32'(aBusy), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 1'b1, 5'd10, W0);
        set_req(2, 1'b1, 5'd11, W2);
        #1;
        chk("rst_no_wen", 32'(wEnable), 32'h0);
        chk("rst_busy_clear", 32'(aBusy), 32'h0);
        chk("rst_grant0", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("rst_after_dr", 32'(dR), 32'd10);

        // Random traffic compared with the reference model.
        do_reset();
        ptr_m = NREQ - 1;
        busy_m = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom());
            mark_en  = ($urandom_range(0, 3) == 0);
            mark_reg = 5'($urandom_range(0, 7));
            rA       = 5'($urandom_range(0, 7));
            rB       = 5'($urandom_range(0, 7));
            reset    = ($urandom_range(0, 79) == 0);
            #1;
            gi = -1;
            if (!reset)
                for (int k = 1; k <= NREQ; k++) begin
                    j = (ptr_m + k) % NREQ;
                    if (gi < 0 && bus.req_valid[j]) gi = j;
                end
            exp_ready = (gi >= 0) ? 3'(3'b001 << gi) : 3'b000;
            exp_wen   = (exp_q.size() > 0);
            head      = exp_wen ? exp_q[0] : 37'h0;
            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rnd_abusy", 32'(aBusy), 32'(busy_m[rA]));
            chk("rnd_bbusy", 32'(bBusy), 32'(busy_m[rB]));
            chk("rnd_wen", 32'(wEnable), 32'(exp_wen));
            chk("rnd_idle", 32'(idle), 32'((busy_m == 0) && !exp_wen && (bus.req_valid == 0)));
            if (exp_wen) begin
                chk("rnd_dr", 32'(dR), 32'(head[36:32]));
                chk("rnd_wdata", wData, head[31:0]);
            end
            if (reset) begin
                ptr_m = NREQ - 1;
                busy_m = '0;
                exp_q.delete();
            end else begin
                if (exp_wen) begin
                    busy_m[head[36:32]] = 1'b0;
                    void'(exp_q.pop_front());
                end
                if (mark_en) busy_m[mark_reg] = 1'b1;
                busy_m[0] = 1'b0;
                if (gi >= 0) begin
                    ptr_m = gi;
                    d = bus.req_dR[5*gi +: 5];
                    if (d != 5'd0) exp_q.push_back({d, bus.req_wData[32*gi +: 32]});
                end
            end
            @(negedge clk);
            if (gi >= 0) drop(gi);
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
